// File: rtl/softmax_pkg.sv
// Shared sizing defaults for the softmax output row collector.
package softmax_pkg;
  localparam int DEF_D_W   = 8;
  localparam int DEF_N     = 32;
  localparam int DEF_IDX_W = 16;
  localparam int CNT_W     = $clog2(DEF_N) + 1;

  typedef logic signed [DEF_N-1:0][DEF_D_W-1:0] row_t;
endpackage

// File: rtl/row_bank.sv
// One N-entry element bank: indexed write, sync clear, packed row read.
module row_bank
  import softmax_pkg::*;
#(
  parameter int D_W = DEF_D_W,
  parameter int N   = DEF_N,
  parameter int AW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    idx_i,
  input  logic [D_W-1:0]   d_i,
  output logic [N*D_W-1:0] row_o
);

  logic [N-1:0][D_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= d_i;
    end
  end

  assign row_o = mem_q;

endmodule

// File: rtl/softmax_row_collector.sv
// Packs softmax elements into ping-pong row banks with a valid/ready drain.
// Optional SOFTMAX_COLLECT_ROWSUM_EN adds a per-row signed sum output.
module softmax_row_collector
  import softmax_pkg::*;
#(
  parameter int D_W   = DEF_D_W,
  parameter int N     = DEF_N,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [D_W-1:0] qin,
  output logic                  stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*D_W-1:0]      out_data,
  output logic [IDX_W-1:0]      out_row_idx,
  output logic                  overflow
`ifdef SOFTMAX_COLLECT_ROWSUM_EN
  ,
  output logic signed [D_W+$clog2(N)-1:0] out_rowsum
`endif
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, rd_bank_q;
  logic [CW-1:0]    wr_cntr_q;
  logic [IDX_W-1:0] idx_q;
  logic             ovf_q;

  logic cap, pop, last;
  logic [N*D_W-1:0] row0, row1;

  assign stall = full_q[wr_bank_q];
  assign cap   = in_valid && !stall;
  assign pop   = full_q[rd_bank_q] && out_ready;
  assign last  = (wr_cntr_q == CW'(N - 1));

  row_bank #(.D_W(D_W), .N(N)) u_b0 (
    .clk  (clk),
    .rst  (rst),
    .we_i (cap && !wr_bank_q),
    .idx_i(wr_cntr_q[AW-1:0]),
    .d_i  (qin),
    .row_o(row0)
  );

  row_bank #(.D_W(D_W), .N(N)) u_b1 (
    .clk  (clk),
    .rst  (rst),
    .we_i (cap && wr_bank_q),
    .idx_i(wr_cntr_q[AW-1:0]),
    .d_i  (qin),
    .row_o(row1)
  );

  // A capturing bank is never full and a popping bank always is,
  // so completion and pop always hit different flags.
  always_comb begin
    full_d = full_q;
    if (pop)         full_d[rd_bank_q] = 1'b0;
    if (cap && last) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cntr_q <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      full_q <= full_d;
      if (cap) begin
        if (last) begin
          wr_cntr_q <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_cntr_q <= wr_cntr_q + 1'b1;
        end
      end
      if (in_valid && stall) ovf_q <= 1'b1;
      if (pop) begin
        rd_bank_q <= ~rd_bank_q;
        idx_q     <= idx_q + 1'b1;
      end
    end
  end

  assign out_valid   = full_q[rd_bank_q];
  assign out_data    = rd_bank_q ? row1 : row0;
  assign out_row_idx = idx_q;
  assign overflow    = ovf_q;

`ifdef SOFTMAX_COLLECT_ROWSUM_EN
  localparam int SW = D_W + AW;

  logic signed [SW-1:0] sum_q [2];
  logic signed [SW-1:0] sum_base;
  logic signed [SW-1:0] qin_x;

  assign qin_x    = {{(SW-D_W){qin[D_W-1]}}, qin};
  assign sum_base = (wr_cntr_q == '0) ? '0 : sum_q[wr_bank_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q[0] <= '0;
      sum_q[1] <= '0;
    end else if (cap) begin
      sum_q[wr_bank_q] <= sum_base + qin_x;
    end
  end

  assign out_rowsum = sum_q[rd_bank_q];
`endif

endmodule

// File: tb/tb_softmax_row_collector.sv
// Directed bench for softmax_row_collector: vector table plus corner sequences.
module tb_softmax_row_collector;

  localparam int D_W   = 8;
  localparam int N     = 32;
  localparam int IDX_W = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic signed [D_W-1:0] qin = '0;
  logic                  out_ready = 1'b0;
  logic                  stall;
  logic                  out_valid;
  logic [N*D_W-1:0]      out_data;
  logic [IDX_W-1:0]      out_row_idx;
  logic                  overflow;
`ifdef SOFTMAX_COLLECT_ROWSUM_EN
  logic signed [D_W+$clog2(N)-1:0] out_rowsum;
`endif

  int n_run  = 0;
  int n_fail = 0;

  softmax_row_collector #(.D_W(D_W), .N(N), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .qin        (qin),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row_idx(out_row_idx),
    .overflow   (overflow)
`ifdef SOFTMAX_COLLECT_ROWSUM_EN
    ,
    .out_rowsum (out_rowsum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int base;
    int inc;
    int e0;
    int e31;
    int idx;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int elem(input int k);
    logic signed [D_W-1:0] v;
    v = out_data[k*D_W +: D_W];
    return int'(v);
  endfunction

  function automatic logic signed [D_W-1:0] val(input int b,
                                                 input int i,
                                                 input int k);
    int t;
    t = b + k * i;
    return t[D_W-1:0];
  endfunction

  function automatic int row_bad(input int b, input int i);
    int bad = 0;
    for (int k = 0; k < N; k++)
      if (elem(k) != int'(val(b, i, k))) bad++;
    return bad;
  endfunction

  task automatic push(input int b, input int i, input int cnt,
                      output int stalls);
    stalls = 0;
    for (int k = 0; k < cnt; k++) begin
      in_valid = 1'b1;
      qin = val(b, i, k);
      if (stall) stalls++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int st;
  int p, rows, bad, cyc;
  logic cap_now;

  initial begin
    tbl[0] = '{base: 0,    inc: 1,  e0: 0,    e31: 31,   idx: 0};
    tbl[1] = '{base: -5,   inc: 0,  e0: -5,   e31: -5,   idx: 1};
    tbl[2] = '{base: 100,  inc: 1,  e0: 100,  e31: -125, idx: 2};
    tbl[3] = '{base: -128, inc: -1, e0: -128, e31: 97,   idx: 3};
    tbl[4] = '{base: 7,    inc: 2,  e0: 7,    e31: 69,   idx: 4};

    rst = 1'b1;
    tick();
    tick();
    check("rst stall", stall, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", (out_data == '0), 1);
    check("rst idx", out_row_idx, 0);
    check("rst overflow", overflow, 0);
    rst = 1'b0;

    // Single rows drained immediately
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      push(tbl[v].base, tbl[v].inc, N, st);
      check("tbl stall", st, 0);
      check("tbl valid", out_valid, 1);
      check("tbl e0", elem(0), tbl[v].e0);
      check("tbl e31", elem(31), tbl[v].e31);
      check("tbl idx", out_row_idx, tbl[v].idx);
      check("tbl row", row_bad(tbl[v].base, tbl[v].inc), 0);
      tick();
      check("tbl pulse", out_valid, 0);
    end
    check("tbl overflow", overflow, 0);

    // Both banks fill, then a held element overflows
    do_reset();
    push(0, 1, 2 * N, st);
    check("b2b stall", stall, 1);
    check("b2b valid", out_valid, 1);
    check("b2b idx0", out_row_idx, 0);
    in_valid = 1'b1;
    qin = 8'sd77;
    tick();
    check("b2b ovf", overflow, 1);
    check("b2b hold", row_bad(0, 1), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b unstall", stall, 0);
    check("b2b idx1", out_row_idx, 1);
    check("b2b row1", row_bad(32, 1), 0);
    tick();
    in_valid = 1'b0;
    check("b2b stable", row_bad(32, 1), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b held cap", out_valid, 0);
    push(78, 1, N - 1, st);
    check("b2b resume", out_valid, 1);
    check("b2b resume e0", elem(0), 77);
    check("b2b resume e31", elem(31), 108);
    check("b2b resume idx", out_row_idx, 2);

    // Row completion into B1 and pop of B0 in one cycle
    do_reset();
    push(0, 1, N, st);
    push(32, 1, N - 1, st);
    in_valid = 1'b1;
    qin = 8'sd63;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("sim valid", out_valid, 1);
    check("sim idx", out_row_idx, 1);
    check("sim row", row_bad(32, 1), 0);
    check("sim stall", stall, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sim empty", out_valid, 0);

    // Reset in the middle of a row
    do_reset();
    push(1, 1, 10, st);
    rst = 1'b1;
    tick();
    check("mid rst data", (out_data == '0), 1);
    rst = 1'b0;
    push(-5, 0, N, st);
    check("mid valid", out_valid, 1);
    check("mid row", row_bad(-5, 0), 0);
    check("mid idx", out_row_idx, 0);
    check("mid ovf", overflow, 0);

    // Producer gated by ~stall, consumer ready toggling every 5 cycles
    do_reset();
    p = 0;
    rows = 0;
    bad = 0;
    cyc = 0;
    while (rows < 3 && cyc < 2000) begin
      in_valid = (p < 3 * N);
      qin = val(3, 7, p);
      out_ready = ((cyc / 5) % 2) == 1;
      cap_now = in_valid && !stall;
      if (out_valid && out_ready) begin
        for (int k = 0; k < N; k++)
          if (elem(k) != int'(val(3, 7, rows * N + k))) bad++;
        if (out_row_idx != IDX_W'(rows)) bad++;
        rows++;
      end
      tick();
      if (cap_now) p++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("loop rows", rows, 3);
    check("loop bad", bad, 0);
    check("loop sent", p, 3 * N);
    check("loop ovf", overflow, 0);

`ifdef SOFTMAX_COLLECT_ROWSUM_EN
    do_reset();
    check("sum rst", out_rowsum, 0);
    push(2, 0, N, st);
    check("sum +2", out_rowsum, 64);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(-1, 0, N, st);
    check("sum -1", out_rowsum, -32);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
